// File: rtl/ace_ccu_pkg.sv
// Shared types for the CCU scheduler: FSM states, the CCU port index type and
// the round-robin pointer advance.
package ace_ccu_pkg;

   localparam int unsigned CcuMaxPorts  = 256;
   localparam int unsigned CcuIdxWidth  = $clog2(CcuMaxPorts);

   typedef enum logic [1:0] {IDLE, REQ, BUSY} ccu_sched_state_e;

   typedef logic [CcuIdxWidth-1:0] ccu_port_idx_t;

   // Next round-robin start index; the wrap is explicit so any port count works.
   function automatic ccu_port_idx_t rr_next(input ccu_port_idx_t idx,
                                             input int unsigned   num_ports);
      if ((32'(idx) + 32'd1) >= num_ports) begin
         return '0;
      end
      return idx + ccu_port_idx_t'(1);
   endfunction

endpackage

// File: rtl/ace_ccu_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or above the
// start pointer, otherwise the lowest requesting index below it.
module ace_ccu_rr_pick #(
   parameter int unsigned NumReq   = 2,
   parameter int unsigned IdxWidth = $clog2(NumReq)
) (
   input  logic [NumReq-1:0]   req_i,
   input  logic [IdxWidth-1:0] rr_i,
   output logic [IdxWidth-1:0] idx_o,
   output logic                valid_o
);

   logic                found_hi;
   logic                found_lo;
   logic [IdxWidth-1:0] idx_hi;
   logic [IdxWidth-1:0] idx_lo;

   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         if (req_i[i]) begin
            if (IdxWidth'(i) >= rr_i) begin
               if (!found_hi) begin
                  found_hi = 1'b1;
                  idx_hi   = IdxWidth'(i);
               end
            end else if (!found_lo) begin
               found_lo = 1'b1;
               idx_lo   = IdxWidth'(i);
            end
         end
      end
   end

   assign idx_o   = found_hi ? idx_hi : idx_lo;
   assign valid_o = |req_i;

endmodule

// File: rtl/ace_ccu_sched.sv
// Shares the single CCU snoop engine among the ACE slave ports: shareable
// requests are granted round-robin and held until the CCU reports done,
// non-shareable ones pass straight through to the bypass path.
module ace_ccu_sched
   import ace_ccu_pkg::*;
#(
   parameter int unsigned NoSlvPorts = 2,
   parameter int unsigned IdxWidth   = $clog2(NoSlvPorts)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NoSlvPorts-1:0] slv_req_valid_i,
   input  logic [NoSlvPorts-1:0] slv_req_snoop_i,
   input  logic [NoSlvPorts-1:0] slv_req_write_i,
   output logic [NoSlvPorts-1:0] slv_req_ready_o,
   output logic [NoSlvPorts-1:0] byp_valid_o,
   input  logic [NoSlvPorts-1:0] byp_ready_i,
   output logic                  ccu_valid_o,
   input  logic                  ccu_ready_i,
   output logic [IdxWidth-1:0]   ccu_idx_o,
   output logic                  ccu_write_o,
   input  logic                  ccu_done_i,
   output logic                  busy_o
);

   ccu_sched_state_e      state_q, state_d;
   logic [IdxWidth-1:0]   idx_q, idx_d;
   logic [IdxWidth-1:0]   rr_q, rr_d;
   logic                  wr_q, wr_d;

   logic [NoSlvPorts-1:0] snoop_req;
   logic [IdxWidth-1:0]   pick_idx;
   logic                  pick_valid;
   logic                  ccu_grant;

   assign snoop_req = slv_req_valid_i & slv_req_snoop_i;

   ace_ccu_rr_pick #(
      .NumReq   (NoSlvPorts),
      .IdxWidth (IdxWidth)
   ) i_rr_pick (
      .req_i   (snoop_req),
      .rr_i    (rr_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Next-state logic; a latched grant is only released by ccu_done_i.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      wr_d        = wr_q;
      rr_d        = rr_q;
      ccu_valid_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               idx_d   = pick_idx;
               wr_d    = slv_req_write_i[pick_idx];
               state_d = REQ;
            end
         end
         REQ: begin
            ccu_valid_o = 1'b1;
            if (ccu_ready_i) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (ccu_done_i) begin
               rr_d    = IdxWidth'(rr_next(ccu_port_idx_t'(idx_q), NoSlvPorts));
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         rr_q    <= rr_d;
      end
   end

   assign ccu_grant   = (state_q == REQ) && ccu_ready_i;
   assign ccu_idx_o   = idx_q;
   assign ccu_write_o = wr_q;
   assign busy_o      = (state_q != IDLE);
   assign byp_valid_o = slv_req_valid_i & ~slv_req_snoop_i;

   // Shareable ports see ready only on the CCU hand-off; others follow bypass.
   always_comb begin
      slv_req_ready_o = '0;
      for (int unsigned i = 0; i < NoSlvPorts; i++) begin
         if (slv_req_snoop_i[i]) begin
            slv_req_ready_o[i] = ccu_grant && (idx_q == IdxWidth'(i));
         end else begin
            slv_req_ready_o[i] = byp_valid_o[i] && byp_ready_i[i];
         end
      end
   end

   req_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == REQ) |-> (slv_req_valid_i[idx_q] && slv_req_snoop_i[idx_q] &&
                            (slv_req_write_i[idx_q] == wr_q)));

endmodule
